// File: rtl/fpsu_ret_queue_if.sv
// rtl/fpsu_ret_queue_if.sv - completion-port, retire-stream and flag signals of the FP/SIMD retirement queue
interface fpsu_ret_queue_if #(
    parameter int IIW = 10
);
    logic [13:0]    u1_ret;
    logic           u1_ret_en;
    logic [IIW-1:0] u1_ii;
    logic [13:0]    u3_ret;
    logic           u3_ret_en;
    logic [IIW-1:0] u3_ii;
    logic [13:0]    u5_ret;
    logic           u5_ret_en;
    logic [IIW-1:0] u5_ii;
    logic           out_vld;
    logic [13:0]    out_ret;
    logic [IIW-1:0] out_ii;
    logic           out_rdy;
    logic           stall;
    logic           flg_clr;
    logic [4:0]     flg;
    logic           ovf;

    modport master (
        output u1_ret, u1_ret_en, u1_ii,
        output u3_ret, u3_ret_en, u3_ii,
        output u5_ret, u5_ret_en, u5_ii,
        output out_rdy, flg_clr,
        input  out_vld, out_ret, out_ii, stall, flg, ovf
    );

    modport slave (
        input  u1_ret, u1_ret_en, u1_ii,
        input  u3_ret, u3_ret_en, u3_ii,
        input  u5_ret, u5_ret_en, u5_ii,
        input  out_rdy, flg_clr,
        output out_vld, out_ret, out_ii, stall, flg, ovf
    );
endinterface

// File: rtl/fpsu_ret_queue.sv
// rtl/fpsu_ret_queue.sv - merges three FP/SIMD completion ports into one in-order retire stream
module fpsu_ret_queue #(
    parameter int DEPTH = 8,
    parameter int IIW   = 10
) (
    input  logic          clk,
    input  logic          rst,
    fpsu_ret_queue_if.slave q
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [13:0]    mem_ret [DEPTH];
    logic [IIW-1:0] mem_ii  [DEPTH];

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic [4:0]    flg_r;
    logic          ovf_r;

    logic [AW:0]   free;
    logic          acc1;
    logic          acc3;
    logic          acc5;
    logic [1:0]    n_en;
    logic [1:0]    n_acc;
    logic [1:0]    n_before5;
    logic [AW-1:0] slot3;
    logic [AW-1:0] slot5;
    logic          pop;

    // Accept writes in u1, u3, u5 priority against space measured before this cycle's pop,
    // and compact the accepted ones into consecutive slots starting at wp.
    always_comb begin
        free      = DEPTH_C - cnt;
        acc1      = q.u1_ret_en && (free > '0);
        acc3      = q.u3_ret_en && (free > (AW+1)'(acc1));
        n_before5 = {1'b0, acc1} + {1'b0, acc3};
        acc5      = q.u5_ret_en && (free > (AW+1)'(n_before5));
        n_acc     = n_before5 + {1'b0, acc5};
        n_en      = {1'b0, q.u1_ret_en} + {1'b0, q.u3_ret_en} + {1'b0, q.u5_ret_en};
        slot3     = wp + AW'(acc1);
        slot5     = wp + AW'(n_before5);
        pop       = (cnt != '0) && q.out_rdy;
    end

    // Entry storage; cleared on reset so the head outputs never carry X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_ret[i] <= '0;
                mem_ii[i]  <= '0;
            end
        end else begin
            if (acc1) begin
                mem_ret[wp] <= q.u1_ret;
                mem_ii[wp]  <= q.u1_ii;
            end
            if (acc3) begin
                mem_ret[slot3] <= q.u3_ret;
                mem_ii[slot3]  <= q.u3_ii;
            end
            if (acc5) begin
                mem_ret[slot5] <= q.u5_ret;
                mem_ii[slot5]  <= q.u5_ii;
            end
        end
    end

    // Pointers and occupancy; full/empty come from cnt only, never from pointer equality.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(n_acc);
            if (pop) begin
                rp <= rp + AW'(1);
            end
            cnt <= cnt + (AW+1)'(n_acc) - (AW+1)'(pop);
        end
    end

    // Sticky exception flags from popped entries (clear wins) and sticky dropped-write flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flg_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            if (q.flg_clr) begin
                flg_r <= '0;
            end else if (pop) begin
                flg_r <= flg_r | mem_ret[rp][4:0];
            end
            if (n_en > n_acc) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign q.out_vld = (cnt != '0);
    assign q.out_ret = mem_ret[rp];
    assign q.out_ii  = mem_ii[rp];
    assign q.stall   = (free < (AW+1)'(3));
    assign q.flg     = flg_r;
    assign q.ovf     = ovf_r;
endmodule

// File: tb/tb_fpsu_ret_queue.sv
// tb/tb_fpsu_ret_queue.sv - randomized and directed bench for fpsu_ret_queue against a queue model
module tb_fpsu_ret_queue;
    localparam int DEPTH = 8;
    localparam int IIW   = 10;

    typedef struct packed {
        logic [13:0]    ret;
        logic [IIW-1:0] ii;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpsu_ret_queue_if #(.IIW(IIW)) q_if();

    fpsu_ret_queue #(.DEPTH(DEPTH), .IIW(IIW)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q_if)
    );

    ent_t       m_q[$];
    logic [4:0] m_flg;
    logic       m_ovf;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic ent_t mk(input logic [13:0] r, input logic [IIW-1:0] i);
        ent_t e;
        e.ret = r;
        e.ii  = i;
        return e;
    endfunction

    task automatic idle_inputs();
        q_if.u1_ret_en = 0; q_if.u3_ret_en = 0; q_if.u5_ret_en = 0;
        q_if.u1_ret = '0;   q_if.u3_ret = '0;   q_if.u5_ret = '0;
        q_if.u1_ii  = '0;   q_if.u3_ii  = '0;   q_if.u5_ii  = '0;
        q_if.out_rdy = 0;   q_if.flg_clr = 0;
    endtask

    // One clock edge with rst high: advance the reference queue from the current inputs.
    task automatic tick();
        int   free;
        bit   do_pop;
        bit   clr;
        ent_t popped;
        ent_t w[$];
        free   = DEPTH - m_q.size();
        do_pop = (m_q.size() != 0) && q_if.out_rdy;
        clr    = q_if.flg_clr;
        if (do_pop) popped = m_q[0];
        if (q_if.u1_ret_en) w.push_back(mk(q_if.u1_ret, q_if.u1_ii));
        if (q_if.u3_ret_en) w.push_back(mk(q_if.u3_ret, q_if.u3_ii));
        if (q_if.u5_ret_en) w.push_back(mk(q_if.u5_ret, q_if.u5_ii));
        @(posedge clk);
        #1;
        if (do_pop) void'(m_q.pop_front());
        for (int i = 0; i < w.size(); i++) begin
            if (i < free) m_q.push_back(w[i]);
            else m_ovf = 1;
        end
        if (clr) m_flg = '0;
        else if (do_pop) m_flg = m_flg | popped.ret[4:0];
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        m_q.delete();
        m_flg = '0;
        m_ovf = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        q_if.u1_ret_en = 1; q_if.u3_ret_en = 1; q_if.u5_ret_en = 1;
        q_if.u1_ii = 10'd1; q_if.u3_ii = 10'd2; q_if.u5_ii = 10'd3;
        #1 rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++; if (q_if.out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld cyc%0d: got %b want 0", c, q_if.out_vld); end
            n_checks++; if (q_if.flg !== 5'd0) begin n_fail++; $display("FAIL rst_flg cyc%0d: got %b want 0", c, q_if.flg); end
            n_checks++; if (q_if.ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf cyc%0d: got %b want 0", c, q_if.ovf); end
            n_checks++; if (q_if.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall cyc%0d: got %b want 0", c, q_if.stall); end
            n_checks++; if (dut.cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt cyc%0d: got %0d want 0", c, dut.cnt); end
        end
        rst = 1;
        m_q.delete(); m_flg = '0; m_ovf = 0;
        #1;
        n_checks++; if (q_if.out_vld !== 1'b0) begin n_fail++; $display("FAIL post_rst_vld: got %b want 0", q_if.out_vld); end
        n_checks++; if (q_if.out_ii !== 10'd0) begin n_fail++; $display("FAIL post_rst_ii: got %0d want 0", q_if.out_ii); end
        tick();
        n_checks++; if (q_if.out_vld !== 1'b1) begin n_fail++; $display("FAIL first_capture_vld: got %b want 1", q_if.out_vld); end
        n_checks++; if (q_if.out_ii !== 10'd1) begin n_fail++; $display("FAIL first_capture_ii: got %0d want 1", q_if.out_ii); end
        idle_inputs();
        q_if.out_rdy = 1;
        repeat (3) tick();
        n_checks++; if (q_if.out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_drain_vld: got %b want 0", q_if.out_vld); end
    endtask

    task automatic test_ordering();
        logic [IIW-1:0] exp_ii;
        idle_inputs();
        q_if.u1_ret_en = 1; q_if.u3_ret_en = 1; q_if.u5_ret_en = 1;
        q_if.u1_ii = 10'd5; q_if.u3_ii = 10'd6; q_if.u5_ii = 10'd7;
        q_if.out_rdy = 1;
        tick();
        q_if.u1_ret_en = 0; q_if.u3_ret_en = 0; q_if.u5_ret_en = 0;
        for (int k = 0; k < 3; k++) begin
            exp_ii = IIW'(5 + k);
            n_checks++; if (q_if.out_vld !== 1'b1) begin n_fail++; $display("FAIL order_vld %0d: got %b want 1", k, q_if.out_vld); end
            n_checks++; if (q_if.out_ii !== exp_ii) begin n_fail++; $display("FAIL order_ii %0d: got %0d want %0d", k, q_if.out_ii, exp_ii); end
            tick();
        end
        n_checks++; if (q_if.out_vld !== 1'b0) begin n_fail++; $display("FAIL order_empty: got %b want 0", q_if.out_vld); end
    endtask

    task automatic test_wrap();
        logic [IIW-1:0] exp_ii;
        logic [IIW-1:0] seq [3];
        do_reset();
        for (int c = 0; c < 2; c++) begin
            q_if.u1_ret_en = 1; q_if.u3_ret_en = 1; q_if.u5_ret_en = 1;
            q_if.u1_ii = IIW'(100 + 3*c); q_if.u3_ii = IIW'(101 + 3*c); q_if.u5_ii = IIW'(102 + 3*c);
            tick();
        end
        idle_inputs();
        q_if.out_rdy = 1;
        repeat (6) tick();
        n_checks++; if (q_if.out_vld !== 1'b0) begin n_fail++; $display("FAIL wrap_drained: got %b want 0", q_if.out_vld); end
        idle_inputs();
        q_if.u3_ret_en = 1; q_if.u3_ii = 10'd9;
        q_if.u5_ret_en = 1; q_if.u5_ii = 10'd10;
        tick();
        idle_inputs();
        q_if.u1_ret_en = 1; q_if.u1_ii = 10'd11;
        tick();
        idle_inputs();
        n_checks++; if (dut.mem_ii[6] !== 10'd9) begin n_fail++; $display("FAIL wrap_slot6: got %0d want 9", dut.mem_ii[6]); end
        n_checks++; if (dut.mem_ii[7] !== 10'd10) begin n_fail++; $display("FAIL wrap_slot7: got %0d want 10", dut.mem_ii[7]); end
        n_checks++; if (dut.mem_ii[0] !== 10'd11) begin n_fail++; $display("FAIL wrap_slot0: got %0d want 11", dut.mem_ii[0]); end
        seq[0] = 10'd9; seq[1] = 10'd10; seq[2] = 10'd11;
        q_if.out_rdy = 1;
        for (int k = 0; k < 3; k++) begin
            exp_ii = seq[k];
            n_checks++; if (q_if.out_ii !== exp_ii) begin n_fail++; $display("FAIL wrap_pop %0d: got %0d want %0d", k, q_if.out_ii, exp_ii); end
            tick();
        end
        n_checks++; if (q_if.out_vld !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b want 0", q_if.out_vld); end
    endtask

    task automatic test_overflow();
        logic [IIW-1:0] exp_ii;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            q_if.u1_ret_en = 1; q_if.u3_ret_en = (c < 2); q_if.u5_ret_en = (c < 2);
            q_if.u1_ii = IIW'(30 + 3*c); q_if.u3_ii = IIW'(31 + 3*c); q_if.u5_ii = IIW'(32 + 3*c);
            tick();
        end
        n_checks++; if (q_if.stall !== 1'b1) begin n_fail++; $display("FAIL ovf_pre_stall: got %b want 1", q_if.stall); end
        n_checks++; if (q_if.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b want 0", q_if.ovf); end
        q_if.u1_ret_en = 1; q_if.u3_ret_en = 1; q_if.u5_ret_en = 1;
        q_if.u1_ii = 10'd40; q_if.u3_ii = 10'd41; q_if.u5_ii = 10'd42;
        q_if.out_rdy = 1;
        tick();
        idle_inputs();
        n_checks++; if (q_if.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", q_if.ovf); end
        n_checks++; if (q_if.stall !== 1'b1) begin n_fail++; $display("FAIL ovf_stall: got %b want 1", q_if.stall); end
        n_checks++; if (dut.cnt !== 4'd7) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 7", dut.cnt); end
        q_if.out_rdy = 1;
        for (int k = 0; k < 7; k++) begin
            exp_ii = (k < 6) ? IIW'(31 + k) : 10'd40;
            n_checks++; if (q_if.out_ii !== exp_ii) begin n_fail++; $display("FAIL ovf_drain %0d: got %0d want %0d", k, q_if.out_ii, exp_ii); end
            tick();
        end
        n_checks++; if (q_if.out_vld !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", q_if.out_vld); end
        n_checks++; if (q_if.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", q_if.ovf); end
    endtask

    task automatic test_flags();
        do_reset();
        q_if.u1_ret_en = 1; q_if.u3_ret_en = 1; q_if.u5_ret_en = 1;
        q_if.u1_ret = {9'h1a5, 5'b00001}; q_if.u3_ret = {9'h0c3, 5'b10000}; q_if.u5_ret = {9'h155, 5'b00100};
        q_if.u1_ii = 10'd50; q_if.u3_ii = 10'd51; q_if.u5_ii = 10'd52;
        tick();
        idle_inputs();
        n_checks++; if (q_if.flg !== 5'b00000) begin n_fail++; $display("FAIL flg_no_pop: got %b want 00000", q_if.flg); end
        q_if.out_rdy = 1;
        tick();
        n_checks++; if (q_if.flg !== 5'b00001) begin n_fail++; $display("FAIL flg_first: got %b want 00001", q_if.flg); end
        tick();
        n_checks++; if (q_if.flg !== 5'b10001) begin n_fail++; $display("FAIL flg_accum: got %b want 10001", q_if.flg); end
        q_if.flg_clr = 1;
        tick();
        q_if.flg_clr = 0;
        n_checks++; if (q_if.flg !== 5'b00000) begin n_fail++; $display("FAIL flg_clr_wins: got %b want 00000", q_if.flg); end
        n_checks++; if (q_if.out_vld !== 1'b0) begin n_fail++; $display("FAIL flg_empty: got %b want 0", q_if.out_vld); end
    endtask

    task automatic test_back_to_back();
        logic exp_stall;
        do_reset();
        q_if.u1_ret_en = 1; q_if.u3_ret_en = 1; q_if.u5_ret_en = 1;
        q_if.u1_ret = 14'h2a7c; q_if.u1_ii = 10'd3; q_if.u3_ii = 10'd4; q_if.u5_ii = 10'd5;
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            q_if.u1_ret_en = 1; q_if.u1_ii = IIW'(60 + c); q_if.u1_ret = 14'($urandom);
            tick();
            exp_stall = ((4 + c) >= 6);
            n_checks++; if (q_if.out_ii !== 10'd3) begin n_fail++; $display("FAIL bp_hold_ii %0d: got %0d want 3", c, q_if.out_ii); end
            n_checks++; if (q_if.out_ret !== 14'h2a7c) begin n_fail++; $display("FAIL bp_hold_ret %0d: got %h want 2a7c", c, q_if.out_ret); end
            n_checks++; if (q_if.stall !== exp_stall) begin n_fail++; $display("FAIL bp_stall %0d: got %b want %b", c, q_if.stall, exp_stall); end
        end
        idle_inputs();
        q_if.out_rdy = 1;
        tick();
        n_checks++; if (q_if.out_ii !== 10'd4) begin n_fail++; $display("FAIL bp_release: got %0d want 4", q_if.out_ii); end
        n_checks++; if (q_if.stall !== 1'b1) begin n_fail++; $display("FAIL bp_stall_after_pop: got %b want 1", q_if.stall); end
    endtask

    task automatic test_random();
        int rdy_pct;
        logic exp_stall;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(10, 95);
            q_if.u1_ret_en = ($urandom_range(0, 99) < 45);
            q_if.u3_ret_en = ($urandom_range(0, 99) < 45);
            q_if.u5_ret_en = ($urandom_range(0, 99) < 45);
            q_if.u1_ret = 14'($urandom); q_if.u3_ret = 14'($urandom); q_if.u5_ret = 14'($urandom);
            q_if.u1_ii = IIW'($urandom); q_if.u3_ii = IIW'($urandom); q_if.u5_ii = IIW'($urandom);
            q_if.out_rdy = ($urandom_range(0, 99) < rdy_pct);
            q_if.flg_clr = ($urandom_range(0, 99) < 4);
            exp_stall = ((DEPTH - m_q.size()) < 3);
            n_checks++; if (q_if.out_vld !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_vld cyc%0d: got %b want %b", c, q_if.out_vld, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                n_checks++; if (q_if.out_ii !== m_q[0].ii) begin n_fail++; $display("FAIL rnd_ii cyc%0d: got %0d want %0d", c, q_if.out_ii, m_q[0].ii); end
                n_checks++; if (q_if.out_ret !== m_q[0].ret) begin n_fail++; $display("FAIL rnd_ret cyc%0d: got %h want %h", c, q_if.out_ret, m_q[0].ret); end
            end
            n_checks++; if (q_if.stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall cyc%0d: got %b want %b", c, q_if.stall, exp_stall); end
            n_checks++; if (q_if.flg !== m_flg) begin n_fail++; $display("FAIL rnd_flg cyc%0d: got %b want %b", c, q_if.flg, m_flg); end
            n_checks++; if (q_if.ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc%0d: got %b want %b", c, q_if.ovf, m_ovf); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_flg = '0;
        m_ovf = 0;
        test_reset();
        test_ordering();
        test_wrap();
        test_overflow();
        test_flags();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
